// File: rtl/imm_decode_stage.sv
// RISC-V immediate decode stage: per-format immediate extraction behind a 2-entry skid buffer.
// Optional macro IMM_DECODE_ZICSR_EN adds ZIMM (CSR*I) decoding for SYSTEM instructions.
module imm_decode_stage #(
    parameter int XLEN  = 32,   // 32 or 64 only
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_inst,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_fmt,
    output logic [TAG_W-1:0] out_tag
);

    typedef enum logic [2:0] {
        FMT_NONE  = 3'd0,
        FMT_I     = 3'd1,
        FMT_S     = 3'd2,
        FMT_B     = 3'd3,
        FMT_U     = 3'd4,
        FMT_J     = 3'd5,
        FMT_SHAMT = 3'd6,
        FMT_ZIMM  = 3'd7
    } fmt_e;

    localparam bit IS_RV64 = (XLEN == 64);

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_IMM32  = 7'b0011011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    // ---------------- combinational decode of the incoming word ----------------
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_shamt, imm_shamt5, imm_zimm;
    logic            is_shift;
    logic [XLEN-1:0] dec_imm;
    fmt_e            dec_fmt;

    assign imm_i      = XLEN'($signed(in_inst[31:20]));
    assign imm_s      = XLEN'($signed({in_inst[31:25], in_inst[11:7]}));
    assign imm_b      = XLEN'($signed({in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0}));
    assign imm_u      = XLEN'($signed({in_inst[31:12], 12'b0}));
    assign imm_j      = XLEN'($signed({in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0}));
    assign imm_shamt5 = XLEN'(in_inst[24:20]);
    assign imm_shamt  = IS_RV64 ? XLEN'(in_inst[25:20]) : imm_shamt5;
    assign imm_zimm   = XLEN'(in_inst[19:15]);
    // funct3 001 (SLLI) or 101 (SRLI/SRAI)
    assign is_shift   = (in_inst[13:12] == 2'b01);

    always_comb begin
        dec_imm = '0;
        dec_fmt = FMT_NONE;
        case (in_inst[6:0])
            OP_IMM: begin
                if (is_shift) begin
                    dec_imm = imm_shamt;
                    dec_fmt = FMT_SHAMT;
                end else begin
                    dec_imm = imm_i;
                    dec_fmt = FMT_I;
                end
            end
            OP_LOAD, OP_JALR: begin
                dec_imm = imm_i;
                dec_fmt = FMT_I;
            end
            OP_STORE: begin
                dec_imm = imm_s;
                dec_fmt = FMT_S;
            end
            OP_BRANCH: begin
                dec_imm = imm_b;
                dec_fmt = FMT_B;
            end
            OP_LUI, OP_AUIPC: begin
                dec_imm = imm_u;
                dec_fmt = FMT_U;
            end
            OP_JAL: begin
                dec_imm = imm_j;
                dec_fmt = FMT_J;
            end
            OP_IMM32: begin
                if (IS_RV64) begin
                    dec_imm = is_shift ? imm_shamt5 : imm_i;
                    dec_fmt = is_shift ? FMT_SHAMT : FMT_I;
                end
            end
`ifdef IMM_DECODE_ZICSR_EN
            OP_SYSTEM: begin
                if (in_inst[14]) begin
                    dec_imm = imm_zimm;
                    dec_fmt = FMT_ZIMM;
                end
            end
`else
            OP_SYSTEM: begin
                dec_imm = '0;
                dec_fmt = FMT_NONE;
            end
`endif
            default: begin
                dec_imm = '0;
                dec_fmt = FMT_NONE;
            end
        endcase
    end

`ifndef IMM_DECODE_ZICSR_EN
    logic unused_zimm;
    assign unused_zimm = ^imm_zimm;
`endif

    // ---------------- skid buffer: output register + skid register ----------------
    logic             out_valid_q, out_valid_d;
    logic [XLEN-1:0]  out_imm_q, out_imm_d;
    fmt_e             out_fmt_q, out_fmt_d;
    logic [TAG_W-1:0] out_tag_q, out_tag_d;
    logic             skid_valid_q, skid_valid_d;
    logic [XLEN-1:0]  skid_imm_q, skid_imm_d;
    fmt_e             skid_fmt_q, skid_fmt_d;
    logic [TAG_W-1:0] skid_tag_q, skid_tag_d;

    assign in_ready  = !skid_valid_q;
    assign out_valid = out_valid_q;
    assign out_imm   = out_imm_q;
    assign out_fmt   = out_fmt_q;
    assign out_tag   = out_tag_q;

    always_comb begin
        out_valid_d  = out_valid_q;
        out_imm_d    = out_imm_q;
        out_fmt_d    = out_fmt_q;
        out_tag_d    = out_tag_q;
        skid_valid_d = skid_valid_q;
        skid_imm_d   = skid_imm_q;
        skid_fmt_d   = skid_fmt_q;
        skid_tag_d   = skid_tag_q;
        if (flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!out_valid_q || out_ready) begin
            // Output slot frees up: the older skid entry has priority over new input.
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_imm_d    = skid_imm_q;
                out_fmt_d    = skid_fmt_q;
                out_tag_d    = skid_tag_q;
                skid_valid_d = 1'b0;
            end else if (in_valid) begin
                out_valid_d = 1'b1;
                out_imm_d   = dec_imm;
                out_fmt_d   = dec_fmt;
                out_tag_d   = in_tag;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (in_valid && !skid_valid_q) begin
            skid_valid_d = 1'b1;
            skid_imm_d   = dec_imm;
            skid_fmt_d   = dec_fmt;
            skid_tag_d   = in_tag;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            out_imm_q    <= '0;
            out_fmt_q    <= FMT_NONE;
            out_tag_q    <= '0;
            skid_valid_q <= 1'b0;
            skid_imm_q   <= '0;
            skid_fmt_q   <= FMT_NONE;
            skid_tag_q   <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_imm_q    <= out_imm_d;
            out_fmt_q    <= out_fmt_d;
            out_tag_q    <= out_tag_d;
            skid_valid_q <= skid_valid_d;
            skid_imm_q   <= skid_imm_d;
            skid_fmt_q   <= skid_fmt_d;
            skid_tag_q   <= skid_tag_d;
        end
    end

endmodule

// File: tb/tb_imm_decode_stage.sv
// Scoreboard bench for imm_decode_stage: RV32 and RV64 instances share one stimulus stream.
module tb_imm_decode_stage;

    localparam int TAG_W = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             flush = 1'b0;
    logic             in_valid = 1'b0;
    logic [31:0]      in_inst = '0;
    logic [TAG_W-1:0] in_tag = '0;
    logic             out_ready = 1'b0;

    logic             in_ready32, in_ready64, out_valid32, out_valid64;
    logic [31:0]      out_imm32;
    logic [63:0]      out_imm64;
    logic [2:0]       out_fmt32, out_fmt64;
    logic [TAG_W-1:0] out_tag32, out_tag64;

    always #5 clk = ~clk;

    imm_decode_stage #(.XLEN(32), .TAG_W(TAG_W)) dut32 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready32),
        .in_inst(in_inst), .in_tag(in_tag), .out_valid(out_valid32), .out_ready(out_ready),
        .out_imm(out_imm32), .out_fmt(out_fmt32), .out_tag(out_tag32));

    imm_decode_stage #(.XLEN(64), .TAG_W(TAG_W)) dut64 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready64),
        .in_inst(in_inst), .in_tag(in_tag), .out_valid(out_valid64), .out_ready(out_ready),
        .out_imm(out_imm64), .out_fmt(out_fmt64), .out_tag(out_tag64));

    int tests = 0;
    int fails = 0;
    int npop  = 0;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endfunction

    // Reference model: immediates as signed integers, then truncated to XLEN.
    function automatic void ref_decode(input logic [31:0] inst, input int xlen,
                                       output logic [63:0] imm, output logic [2:0] fmt);
        longint v;
        logic [2:0] f3;
        f3  = inst[14:12];
        v   = 0;
        fmt = 3'd0;
        case (inst[6:0])
            7'h13: begin
                if (f3 == 3'd1 || f3 == 3'd5) begin
                    fmt = 3'd6;
                    v = (xlen == 64) ? longint'(inst[25:20]) : longint'(inst[24:20]);
                end else begin
                    fmt = 3'd1; v = longint'($signed(inst[31:20]));
                end
            end
            7'h03, 7'h67: begin fmt = 3'd1; v = longint'($signed(inst[31:20])); end
            7'h23: begin fmt = 3'd2; v = longint'($signed({inst[31:25], inst[11:7]})); end
            7'h63: begin fmt = 3'd3; v = longint'($signed({inst[31], inst[7], inst[30:25], inst[11:8]})) * 2; end
            7'h37, 7'h17: begin fmt = 3'd4; v = longint'($signed(inst[31:12])) * 4096; end
            7'h6F: begin fmt = 3'd5; v = longint'($signed({inst[31], inst[19:12], inst[20], inst[30:21]})) * 2; end
            7'h1B: begin
                if (xlen == 64) begin
                    if (f3 == 3'd1 || f3 == 3'd5) begin fmt = 3'd6; v = longint'(inst[24:20]); end
                    else begin fmt = 3'd1; v = longint'($signed(inst[31:20])); end
                end
            end
`ifdef IMM_DECODE_ZICSR_EN
            7'h73: if (f3 >= 3'd4) begin fmt = 3'd7; v = longint'(inst[19:15]); end
`endif
            default: ;
        endcase
        imm = (xlen == 32) ? {32'h0, v[31:0]} : v;
    endfunction

    typedef struct {
        logic [63:0]      e32;
        logic [63:0]      e64;
        logic [2:0]       f32;
        logic [2:0]       f64;
        logic [TAG_W-1:0] tag;
    } exp_t;
    exp_t sb_q[$];

    logic             stall_prev = 1'b0;
    logic [31:0]      hold_imm;
    logic [2:0]       hold_fmt;
    logic [TAG_W-1:0] hold_tag;

    // Monitor + scoreboard, sampled at the falling edge while inputs are stable.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            sb_q.delete();
            stall_prev = 1'b0;
        end else begin
            if (stall_prev && !flush && out_valid32) begin
                check("hold_imm", {32'h0, out_imm32}, {32'h0, hold_imm});
                check("hold_tag", 64'(out_tag32), 64'(hold_tag));
                check("hold_fmt", 64'(out_fmt32), 64'(hold_fmt));
            end
            stall_prev = out_valid32 && !out_ready;
            hold_imm = out_imm32; hold_fmt = out_fmt32; hold_tag = out_tag32;
            if (!flush && out_valid32 && out_ready) begin
                npop++;
                if (sb_q.size() == 0) begin
                    check("unexpected_output_tag", 64'(out_tag32), 64'hDEAD);
                end else begin
                    e = sb_q.pop_front();
                    check("tag", 64'(out_tag32), 64'(e.tag));
                    check("imm32", {32'h0, out_imm32}, e.e32);
                    check("fmt32", 64'(out_fmt32), 64'(e.f32));
                    check("valid64", 64'(out_valid64), 64'd1);
                    check("imm64", out_imm64, e.e64);
                    check("fmt64", 64'(out_fmt64), 64'(e.f64));
                end
            end
            if (flush) begin
                sb_q.delete();
            end else if (in_valid && in_ready32) begin
                ref_decode(in_inst, 32, e.e32, e.f32);
                ref_decode(in_inst, 64, e.e64, e.f64);
                e.tag = in_tag;
                sb_q.push_back(e);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Hold one instruction valid until accepted (bounded).
    task automatic send_one(input logic [31:0] inst, input logic [TAG_W-1:0] tag);
        logic acc;
        int cnt;
        cnt = 0;
        in_valid = 1'b1; in_inst = inst; in_tag = tag;
        do begin
            @(negedge clk);
            acc = in_ready32;
            step();
            cnt++;
        end while (!acc && cnt < 50);
        if (!acc) check("send_timeout", 64'd0, 64'd1);
        in_valid = 1'b0;
    endtask

    // Single transfer into an idle stage; output must appear one cycle later.
    task automatic directed(input logic [31:0] inst, input logic [63:0] x32,
                            input logic [63:0] x64, input logic [2:0] f, input logic [TAG_W-1:0] tag);
        out_ready = 1'b1;
        send_one(inst, tag);
        check("dir_valid", 64'(out_valid32), 64'd1);
        check("dir_imm32", {32'h0, out_imm32}, x32);
        check("dir_imm64", out_imm64, x64);
        check("dir_fmt", 64'(out_fmt32), 64'(f));
        check("dir_tag", 64'(out_tag32), 64'(tag));
        step();
    endtask

    logic [6:0] ops [12] = '{7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37,
                             7'h17, 7'h6F, 7'h1B, 7'h73, 7'h33, 7'h7F};

    initial begin
        int pops_before;
        logic [TAG_W-1:0] t;
        // Reset state (asynchronous: checked without any clock edge)
        #2;
        check("rst_out_valid", 64'(out_valid32), 64'd0);
        check("rst_out_imm", {32'h0, out_imm32}, 64'd0);
        check("rst_out_fmt", 64'(out_fmt32), 64'd0);
        check("rst_out_tag", 64'(out_tag32), 64'd0);
        step(); step();
        rst = 1'b0;
        step();
        check("rst_in_ready", 64'(in_ready32), 64'd1);

        directed(32'hFFF00093, 64'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 3'd1, 8'd10);
        directed(32'hFE000EE3, 64'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 3'd3, 8'd11);
        directed(32'h4030D093, 64'h3, 64'h3, 3'd6, 8'd12);
        directed(32'h800000B7, 64'h80000000, 64'hFFFFFFFF80000000, 3'd4, 8'd13);
`ifdef IMM_DECODE_ZICSR_EN
        directed(32'h3002D073, 64'h5, 64'h5, 3'd7, 8'd14);
`else
        directed(32'h3002D073, 64'h0, 64'h0, 3'd0, 8'd14);
`endif

        // Backpressure: tags 1,2,3 offered while out_ready=0 for 3 cycles
        pops_before = npop;
        out_ready = 1'b0;
        in_valid = 1'b1; in_inst = 32'h00100093; in_tag = 8'd1;
        step();
        in_tag = 8'd2; in_inst = 32'h00200093;
        step();
        check("bp_in_ready_full", 64'(in_ready32), 64'd0);
        in_tag = 8'd3; in_inst = 32'h00300093;
        step();
        check("bp_in_ready_still", 64'(in_ready32), 64'd0);
        check("bp_out_tag_held", 64'(out_tag32), 64'd1);
        out_ready = 1'b1;
        step();
        check("bp_skid_moved", 64'(out_tag32), 64'd2);
        check("bp_in_ready_rise", 64'(in_ready32), 64'd1);
        send_one(32'h00300093, 8'd3);
        repeat (3) step();
        check("bp_all_delivered", 64'(npop - pops_before), 64'd3);

        // Flush with both entries full and in_valid=1
        out_ready = 1'b0;
        send_one(32'h00500093, 8'd40);
        send_one(32'h00600093, 8'd41);
        check("fl_full", 64'(in_ready32), 64'd0);
        in_valid = 1'b1; in_tag = 8'd42; flush = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0;
        check("fl_out_valid", 64'(out_valid32), 64'd0);
        check("fl_in_ready", 64'(in_ready32), 64'd1);
        out_ready = 1'b1;
        repeat (3) step();
        check("fl_no_output", 64'(out_valid32), 64'd0);
        directed(32'h00700093, 64'h7, 64'h7, 3'd1, 8'd43);

        // Randomized traffic with occasional flushes
        t = 8'd100;
        for (int i = 0; i < 2000; i++) begin
            in_valid  = ($urandom_range(3) != 0);
            in_inst   = {$urandom_range(32'h1FFFFFF, 0), ops[$urandom_range(11)]};
            in_tag    = t;
            t         = t + 8'd1;
            out_ready = ($urandom_range(2) != 0);
            flush     = ($urandom_range(39) == 0);
            step();
        end
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        repeat (5) step();
        check("drain_empty", 64'(sb_q.size()), 64'd0);

        // Reset mid-transfer drops held entries at once
        out_ready = 1'b0;
        send_one(32'h00800093, 8'd50);
        send_one(32'h00900093, 8'd51);
        #2 rst = 1'b1;
        #1;
        check("arst_out_valid", 64'(out_valid32), 64'd0);
        check("arst_out_tag", 64'(out_tag32), 64'd0);
        check("arst_in_ready", 64'(in_ready32), 64'd1);
        step(); step();
        rst = 1'b0;
        out_ready = 1'b1;
        repeat (3) step();
        check("arst_no_output", 64'(out_valid32), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
